reduction_combiner: RTL and testbench

Parametrised many-to-one reduction stage for the collective router. It buffers one flit per input port and waits until every port selected by a run-time mask holds a flit. It then combines the payloads with a selectable operator and emits a single reduced flit through a valid/ready output register. It sits between the per-port input queues and the output arbiter on the reduction path of each router node.

---
 rtl/reduction_combiner.sv | 182 ++++++++++++++++++
 tb/tb_reduction_combiner.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reduction_combiner.sv
// reduction_combiner
// Many-to-one reduction stage for the collective router. Each input port owns
// one holding slot; once every port selected by expect_mask holds a flit, the
// held payloads are combined with the selected operator and a single reduced
// flit is launched through a valid/ready output register. The header of the
// reduced flit is taken from the lowest-index masked port.

module reduction_combiner #(
  parameter int FAN_IN    = 6,
  parameter int FLIT_SIZE = 82,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FLIT_SIZE*FAN_IN-1:0] in,
  input  logic [FAN_IN-1:0]           in_valid,
  output logic [FAN_IN-1:0]           in_avail,
  input  logic [FAN_IN-1:0]           expect_mask,
  input  logic [1:0]                  op,
  input  logic                        flush,
  output logic [FLIT_SIZE-1:0]        out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CNT_W-1:0]            reduce_count
);

  localparam int HDR_W = FLIT_SIZE - DATA_W;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_MAX = 2'd1;
  localparam logic [1:0] OP_MIN = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  // ---------------------------------------------------------------------------
  // Operator helper: combines an accumulated payload with one more payload.
  // MAX/MIN compare unsigned; ADD wraps naturally at DATA_W bits.
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] apply_op(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] acc,
    input logic [DATA_W-1:0] val
  );
    logic [DATA_W-1:0] res;
    case (sel)
      OP_ADD:  res = acc + val;
      OP_MAX:  res = (acc > val) ? acc : val;
      OP_MIN:  res = (acc < val) ? acc : val;
      OP_OR:   res = acc | val;
      default: res = acc + val;
    endcase
    return res;
  endfunction

  // Holding slots and output register state
  logic [FLIT_SIZE-1:0] hold_flit_r [FAN_IN];
  logic [FAN_IN-1:0]    hold_valid_r;
  logic [FAN_IN-1:0]    hold_valid_nxt_s;
  logic [FLIT_SIZE-1:0] out_r;
  logic                 out_valid_r;
  logic [CNT_W-1:0]     reduce_count_r;

  // Handshake / control terms
  logic [FAN_IN-1:0]    accept_s;
  logic                 gathered_s;
  logic                 out_free_s;
  logic                 fire_s;

  // Reduction datapath results
  logic [DATA_W-1:0]    red_payload_s;
  logic [HDR_W-1:0]     red_header_s;
  logic                 red_found_s;

  assign in_avail     = ~hold_valid_r;
  assign out          = out_r;
  assign out_valid    = out_valid_r;
  assign reduce_count = reduce_count_r;

  // Accept, gather-complete and fire decisions; flush blocks accepts and fire.
  always_comb begin
    accept_s   = in_valid & ~hold_valid_r & {FAN_IN{~flush}};
    gathered_s = (expect_mask != {FAN_IN{1'b0}}) &&
                 ((hold_valid_r & expect_mask) == expect_mask);
    out_free_s = ~out_valid_r | out_ready;
    fire_s     = gathered_s & out_free_s & ~flush;
  end

  // Fold the masked held payloads in port order; the first masked port seeds
  // the accumulator and donates the header, so a single-bit mask passes through.
  always_comb begin
    red_payload_s = {DATA_W{1'b0}};
    red_header_s  = {HDR_W{1'b0}};
    red_found_s   = 1'b0;
    for (int i = 0; i < FAN_IN; i++) begin
      if (expect_mask[i]) begin
        if (!red_found_s) begin
          red_payload_s = hold_flit_r[i][DATA_W-1:0];
          red_header_s  = hold_flit_r[i][FLIT_SIZE-1:DATA_W];
          red_found_s   = 1'b1;
        end else begin
          red_payload_s = apply_op(op, red_payload_s, hold_flit_r[i][DATA_W-1:0]);
        end
      end else begin
        red_found_s = red_found_s;
      end
    end
  end

  // Next state of the slot flags: flush clears all, fire frees masked slots,
  // accepts fill free slots. A masked slot is full at fire, so fire and accept
  // never target the same port in one cycle.
  always_comb begin
    hold_valid_nxt_s = hold_valid_r;
    for (int i = 0; i < FAN_IN; i++) begin
      if (flush) begin
        hold_valid_nxt_s[i] = 1'b0;
      end else if (fire_s && expect_mask[i]) begin
        hold_valid_nxt_s[i] = 1'b0;
      end else if (accept_s[i]) begin
        hold_valid_nxt_s[i] = 1'b1;
      end else begin
        hold_valid_nxt_s[i] = hold_valid_r[i];
      end
    end
  end

  // Slot flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid_r <= {FAN_IN{1'b0}};
    end else begin
      hold_valid_r <= hold_valid_nxt_s;
    end
  end

  // Slot payload registers: load the port flit on accept, otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FAN_IN; i++) begin
        hold_flit_r[i] <= {FLIT_SIZE{1'b0}};
      end
    end else begin
      for (int i = 0; i < FAN_IN; i++) begin
        if (accept_s[i]) begin
          hold_flit_r[i] <= in[FLIT_SIZE*i +: FLIT_SIZE];
        end else begin
          hold_flit_r[i] <= hold_flit_r[i];
        end
      end
    end
  end

  // Output register: fire loads a new result (even while draining the old one,
  // giving back-to-back results); a drain without fire empties it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_r       <= {FLIT_SIZE{1'b0}};
      out_valid_r <= 1'b0;
    end else if (fire_s) begin
      out_r       <= {red_header_s, red_payload_s};
      out_valid_r <= 1'b1;
    end else if (out_valid_r && out_ready) begin
      out_r       <= out_r;
      out_valid_r <= 1'b0;
    end else begin
      out_r       <= out_r;
      out_valid_r <= out_valid_r;
    end
  end

  // Completed-reduction counter, wrapping at 2^CNT_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reduce_count_r <= {CNT_W{1'b0}};
    end else if (fire_s) begin
      reduce_count_r <= reduce_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      reduce_count_r <= reduce_count_r;
    end
  end

endmodule

// File: tb/tb_reduction_combiner.sv
// Testbench for reduction_combiner: directed vectors, expected reduced flits
// queued by the stimulus process and checked by an independent output monitor.

module tb_reduction_combiner;

  localparam int FAN_IN    = 6;
  localparam int FLIT_SIZE = 82;
  localparam int DATA_W    = 32;
  localparam int CNT_W     = 16;
  localparam int HDR_W     = FLIT_SIZE - DATA_W;

  logic                        clk;
  logic                        rst;
  logic [FLIT_SIZE*FAN_IN-1:0] in_bus;
  logic [FAN_IN-1:0]           in_valid;
  logic [FAN_IN-1:0]           in_avail;
  logic [FAN_IN-1:0]           expect_mask;
  logic [1:0]                  op;
  logic                        flush;
  logic [FLIT_SIZE-1:0]        out;
  logic                        out_valid;
  logic                        out_ready;
  logic [CNT_W-1:0]            reduce_count;

  int tests;
  int fails;
  logic [FLIT_SIZE-1:0] exp_q[$];

  reduction_combiner #(
    .FAN_IN(FAN_IN), .FLIT_SIZE(FLIT_SIZE), .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in(in_bus), .in_valid(in_valid), .in_avail(in_avail),
    .expect_mask(expect_mask), .op(op), .flush(flush), .out(out),
    .out_valid(out_valid), .out_ready(out_ready), .reduce_count(reduce_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port p always uses header 0xA0+p.
  function automatic logic [FLIT_SIZE-1:0] mk(input int p, input logic [DATA_W-1:0] pay);
    logic [HDR_W-1:0] h;
    h = 50'hA0 + 50'(p);
    return {h, pay};
  endfunction

  task automatic set_port(input int p, input logic [DATA_W-1:0] pay);
    in_bus[FLIT_SIZE*p +: FLIT_SIZE] = mk(p, pay);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [FLIT_SIZE-1:0] act,
                     input logic [FLIT_SIZE-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: every transfer (valid and ready before the edge) pops one expected flit.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: got %0h expected none", out);
      end else begin
        logic [FLIT_SIZE-1:0] e;
        e = exp_q.pop_front();
        if (out !== e) begin
          fails++;
          $display("FAIL out_flit: got %0h expected %0h", out, e);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0; fails = 0;
    rst = 1'b0; in_bus = '0; in_valid = 6'b0; expect_mask = 6'b0;
    op = 2'd0; flush = 1'b0; out_ready = 1'b1;
    #3;
    chk("rst_avail", FLIT_SIZE'(in_avail), FLIT_SIZE'(6'h3F));
    chk("rst_out_valid", FLIT_SIZE'(out_valid), FLIT_SIZE'(1'b0));
    chk("rst_out", out, '0);
    chk("rst_count", FLIT_SIZE'(reduce_count), FLIT_SIZE'(16'd0));
    step();
    rst = 1'b1;
    step();

    // ADD over ports 0,1,2: 5+7+9 = 21, header of port 0
    expect_mask = 6'b000111; op = 2'd0;
    set_port(0, 32'd5); set_port(1, 32'd7); set_port(2, 32'd9);
    in_valid = 6'b000111;
    exp_q.push_back(mk(0, 32'd21));
    step();
    in_valid = 6'b0;
    chk("add_avail_held", FLIT_SIZE'(in_avail), FLIT_SIZE'(6'b111000));
    chk("add_no_out_yet", FLIT_SIZE'(out_valid), FLIT_SIZE'(1'b0));
    step();
    chk("add_out_valid", FLIT_SIZE'(out_valid), FLIT_SIZE'(1'b1));
    chk("add_count", FLIT_SIZE'(reduce_count), FLIT_SIZE'(16'd1));
    chk("add_avail_free", FLIT_SIZE'(in_avail), FLIT_SIZE'(6'h3F));
    step();
    chk("add_pulse", FLIT_SIZE'(out_valid), FLIT_SIZE'(1'b0));

    // MAX over ports 1,5 arriving at different times, header of port 1
    expect_mask = 6'b100010; op = 2'd1;
    set_port(1, 32'h10); in_valid = 6'b000010;
    step();
    in_valid = 6'b0;
    for (int k = 0; k < 2; k++) begin
      chk("max_wait", FLIT_SIZE'(out_valid), FLIT_SIZE'(1'b0));
      step();
    end
    set_port(5, 32'hFFFFFFF0); in_valid = 6'b100000;
    exp_q.push_back(mk(1, 32'hFFFFFFF0));
    step();
    in_valid = 6'b0;
    chk("max_wait_last", FLIT_SIZE'(out_valid), FLIT_SIZE'(1'b0));
    step();
    chk("max_out_valid", FLIT_SIZE'(out_valid), FLIT_SIZE'(1'b1));
    chk("max_count", FLIT_SIZE'(reduce_count), FLIT_SIZE'(16'd2));
    step();

    // ADD wrap: 0xFFFFFFFF + 2 = 1
    op = 2'd0;
    set_port(1, 32'hFFFFFFFF); set_port(5, 32'd2); in_valid = 6'b100010;
    exp_q.push_back(mk(1, 32'd1));
    step();
    in_valid = 6'b0;
    step();
    chk("wrap_count", FLIT_SIZE'(reduce_count), FLIT_SIZE'(16'd3));
    step();

    // Output stall, then back-to-back drain
    out_ready = 1'b0; expect_mask = 6'b000011; op = 2'd0;
    set_port(0, 32'd1); set_port(1, 32'd2); in_valid = 6'b000011;
    exp_q.push_back(mk(0, 32'd3));
    step();
    set_port(0, 32'd10); set_port(1, 32'd20);
    exp_q.push_back(mk(0, 32'd30));
    step();
    step();
    in_valid = 6'b0;
    for (int k = 0; k < 2; k++) begin
      chk("stall_valid", FLIT_SIZE'(out_valid), FLIT_SIZE'(1'b1));
      chk("stall_avail", FLIT_SIZE'(in_avail), FLIT_SIZE'(6'b111100));
      chk("stall_hold_out", out, mk(0, 32'd3));
      step();
    end
    chk("stall_count", FLIT_SIZE'(reduce_count), FLIT_SIZE'(16'd4));
    out_ready = 1'b1;
    step();
    chk("b2b_valid", FLIT_SIZE'(out_valid), FLIT_SIZE'(1'b1));
    chk("b2b_count", FLIT_SIZE'(reduce_count), FLIT_SIZE'(16'd5));
    step();
    chk("b2b_drained", FLIT_SIZE'(out_valid), FLIT_SIZE'(1'b0));

    // Port 3 parked outside the mask across three port-0 passthroughs
    expect_mask = 6'b000001; op = 2'd3;
    set_port(3, 32'h33);
    for (int k = 0; k < 3; k++) begin
      logic [DATA_W-1:0] pay;
      pay = 32'h11 << k;
      set_port(0, pay);
      in_valid = (k == 0) ? 6'b001001 : 6'b000001;
      exp_q.push_back(mk(0, pay));
      step();
      in_valid = 6'b0;
      step();
      chk("park_avail3", FLIT_SIZE'(in_avail[3]), FLIT_SIZE'(1'b0));
    end
    chk("park_count", FLIT_SIZE'(reduce_count), FLIT_SIZE'(16'd8));
    expect_mask = 6'b001000;
    exp_q.push_back(mk(3, 32'h33));
    step();
    chk("park_fire", FLIT_SIZE'(out_valid), FLIT_SIZE'(1'b1));
    chk("park_avail", FLIT_SIZE'(in_avail), FLIT_SIZE'(6'h3F));
    chk("park_count2", FLIT_SIZE'(reduce_count), FLIT_SIZE'(16'd9));
    step();

    // Flush drops held flits, output and counter untouched
    expect_mask = 6'b000111; op = 2'd0;
    set_port(0, 32'd100); set_port(1, 32'd200); in_valid = 6'b000011;
    step();
    in_valid = 6'b0;
    chk("flush_pre", FLIT_SIZE'(in_avail), FLIT_SIZE'(6'b111100));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_avail", FLIT_SIZE'(in_avail), FLIT_SIZE'(6'h3F));
    chk("flush_no_out", FLIT_SIZE'(out_valid), FLIT_SIZE'(1'b0));
    chk("flush_count", FLIT_SIZE'(reduce_count), FLIT_SIZE'(16'd9));
    set_port(2, 32'd300); in_valid = 6'b000100;
    step();
    in_valid = 6'b0;
    step();
    chk("flush_no_fire", FLIT_SIZE'(out_valid), FLIT_SIZE'(1'b0));
    flush = 1'b1;
    step();
    flush = 1'b0;

    // Reset mid-gather with a pending output flit
    out_ready = 1'b0; expect_mask = 6'b000011;
    set_port(0, 32'd1); set_port(1, 32'd1); in_valid = 6'b000011;
    step();
    step();
    step();
    in_valid = 6'b0;
    expect_mask = 6'b000111;
    chk("prerst_valid", FLIT_SIZE'(out_valid), FLIT_SIZE'(1'b1));
    chk("prerst_avail", FLIT_SIZE'(in_avail), FLIT_SIZE'(6'b111100));
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_valid", FLIT_SIZE'(out_valid), FLIT_SIZE'(1'b0));
    chk("midrst_out", out, '0);
    chk("midrst_count", FLIT_SIZE'(reduce_count), FLIT_SIZE'(16'd0));
    chk("midrst_avail", FLIT_SIZE'(in_avail), FLIT_SIZE'(6'h3F));
    step();
    rst = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("postrst_quiet", FLIT_SIZE'(out_valid), FLIT_SIZE'(1'b0));
    end
    chk("postrst_count", FLIT_SIZE'(reduce_count), FLIT_SIZE'(16'd0));

    step();
    chk("queue_empty", FLIT_SIZE'(exp_q.size()), FLIT_SIZE'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
